// File: rtl/l2_ctrl_regs_pkg.sv
// Shared L2 cache control definitions: default geometry, index-width helper, flush FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package l2_ctrl_regs_pkg;

  localparam int unsigned L2_N_SETS  = 256;
  localparam int unsigned L2_N_WAYS  = 8;
  localparam int unsigned L2_N_REQS  = 4;
  localparam int unsigned L2_N_FWD   = 2;
  localparam int unsigned L2_N_FLAGS = 4;

  // Width of an index into n entries; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned L2_SET_W  = idx_w(L2_N_SETS);
  localparam int unsigned L2_WAY_W  = idx_w(L2_N_WAYS);
  localparam int unsigned L2_REQS_W = idx_w(L2_N_REQS);

  typedef enum logic [1:0] {
    FL_IDLE = 2'd0,
    FL_WALK = 2'd1,
    FL_DONE = 2'd2
  } flush_state_e;

endpackage

// File: rtl/l2_fwd_stall_slot.sv
// One forward-stall slot: holds a request index and clears itself when a put retires that index.
// Latency: load and clear take effect on the next clock; match_o is combinational on the current put.
// Backpressure: none; the parent only loads an invalid slot, a loaded slot ignores further loads.
module l2_fwd_stall_slot #(
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [IDX_W-1:0] load_idx_i,
  input  logic             put_valid_i,
  input  logic [IDX_W-1:0] put_idx_i,
  input  logic             put_atomic_i,
  input  logic [IDX_W-1:0] put_atomic_idx_i,
  output logic             vld_o,
  output logic             match_o
);

  logic             vld_q, vld_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Matching looks only at the registered slot, so a same-cycle load can never be retired.
  assign match_o = vld_q & put_valid_i &
                   ((idx_q == put_idx_i) | (put_atomic_i & (idx_q == put_atomic_idx_i)));
  assign vld_o   = vld_q;

  // Next slot contents: a retire clears the slot, a load fills an empty one.
  always_comb begin
    vld_d = vld_q;
    idx_d = idx_q;
    if (match_o) begin
      vld_d = 1'b0;
    end else if (load_i && !vld_q) begin
      vld_d = 1'b1;
      idx_d = load_idx_i;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
      idx_q <= '0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/l2_ctrl_regs.sv
// L2 control registers: flush set/way walker, request-entry credit counter, forward-stall slots, status flags.
// Latency: every register updates one clock after its inputs; full/idle/stall decodes are combinational on registers.
// Backpressure: none; alloc at empty and free at full saturate (sticky err[1:0] when L2_CTRL_REGS_ERR_EN is defined).
module l2_ctrl_regs
  import l2_ctrl_regs_pkg::*;
#(
  parameter  int unsigned N_SETS  = L2_N_SETS,
  parameter  int unsigned N_WAYS  = L2_N_WAYS,
  parameter  int unsigned N_REQS  = L2_N_REQS,
  parameter  int unsigned N_FWD   = L2_N_FWD,
  parameter  int unsigned N_FLAGS = L2_N_FLAGS,
  localparam int unsigned SET_W   = idx_w(N_SETS),
  localparam int unsigned WAY_W   = idx_w(N_WAYS),
  localparam int unsigned REQS_W  = idx_w(N_REQS),
  localparam int unsigned CNT_W   = $clog2(N_REQS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_start,
  input  logic               flush_step,
  input  logic               flush_abort,
  output logic [SET_W-1:0]   flush_set,
  output logic [WAY_W-1:0]   flush_way,
  output logic               flush_busy,
  output logic               flush_done,
  input  logic               req_alloc,
  input  logic               req_free,
  output logic [CNT_W-1:0]   reqs_cnt,
  output logic               reqs_full,
  output logic               reqs_idle,
  input  logic               fwd_push,
  input  logic [REQS_W-1:0]  fwd_push_idx,
  output logic               fwd_stall,
  output logic               fwd_slots_full,
  input  logic               put_valid,
  input  logic [REQS_W-1:0]  put_idx,
  input  logic               put_atomic,
  input  logic [REQS_W-1:0]  put_atomic_idx,
  output logic               fwd_ended,
  input  logic               clr_fwd_ended,
  input  logic [N_FLAGS-1:0] flag_set,
  input  logic [N_FLAGS-1:0] flag_clr,
  output logic [N_FLAGS-1:0] flags
`ifdef L2_CTRL_REGS_ERR_EN
  ,
  output logic [1:0]         err
`endif
);

  localparam logic [SET_W-1:0] SET_LAST = SET_W'(N_SETS - 1);
  localparam logic [WAY_W-1:0] WAY_LAST = WAY_W'(N_WAYS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_REQS);

  flush_state_e       state_q;
  logic [SET_W-1:0]   set_q;
  logic [WAY_W-1:0]   way_q;
  logic               busy_q, done_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ended_q, ended_d;
  logic [N_FLAGS-1:0] flags_q, flags_d;
  logic [N_FWD-1:0]   slot_vld, slot_match, slot_load;
  logic               alloc_only, free_only;

  // Flush walker: IDLE -> WALK on start, one way per step, DONE for a single cycle after the last way.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FL_IDLE;
      set_q   <= '0;
      way_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        FL_IDLE: begin
          if (flush_start) begin
            state_q <= FL_WALK;
            busy_q  <= 1'b1;
          end
        end
        FL_WALK: begin
          if (flush_abort) begin
            state_q <= FL_IDLE;
            busy_q  <= 1'b0;
            set_q   <= '0;
            way_q   <= '0;
          end else if (flush_step) begin
            if (way_q != WAY_LAST) begin
              way_q <= way_q + WAY_W'(1);
            end else if (set_q != SET_LAST) begin
              way_q <= '0;
              set_q <= set_q + SET_W'(1);
            end else begin
              state_q <= FL_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        FL_DONE: begin
          state_q <= FL_IDLE;
          busy_q  <= 1'b0;
          set_q   <= '0;
          way_q   <= '0;
        end
        default: begin
          state_q <= FL_IDLE;
          busy_q  <= 1'b0;
          set_q   <= '0;
          way_q   <= '0;
        end
      endcase
    end
  end

  assign flush_set  = set_q;
  assign flush_way  = way_q;
  assign flush_busy = busy_q;
  assign flush_done = done_q;

  // Alloc and free in the same cycle cancel; one-sided requests saturate at the range ends.
  assign alloc_only = req_alloc & ~req_free;
  assign free_only  = req_free & ~req_alloc;

  // Next free-entry count.
  always_comb begin
    cnt_d = cnt_q;
    if (alloc_only && !reqs_full) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (free_only && !reqs_idle) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign reqs_full = (cnt_q == '0);
  assign reqs_idle = (cnt_q == CNT_MAX);
  assign reqs_cnt  = cnt_q;

  // Pick the lowest empty slot for a push; with no empty slot the push is lost.
  always_comb begin
    logic taken;
    taken     = 1'b0;
    slot_load = '0;
    for (int s = 0; s < N_FWD; s++) begin
      if (!slot_vld[s] && !taken) begin
        slot_load[s] = fwd_push;
        taken        = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_FWD; g++) begin : g_slot
    l2_fwd_stall_slot #(.IDX_W(REQS_W)) u_slot (
      .clk              (clk),
      .rst              (rst),
      .load_i           (slot_load[g]),
      .load_idx_i       (fwd_push_idx),
      .put_valid_i      (put_valid),
      .put_idx_i        (put_idx),
      .put_atomic_i     (put_atomic),
      .put_atomic_idx_i (put_atomic_idx),
      .vld_o            (slot_vld[g]),
      .match_o          (slot_match[g])
    );
  end

  assign fwd_stall      = |slot_vld;
  assign fwd_slots_full = &slot_vld;

  // Sticky "a stalled forward was released" flag; software clear wins over a new release.
  always_comb begin
    ended_d = ended_q;
    if (clr_fwd_ended) begin
      ended_d = 1'b0;
    end else if (|slot_match) begin
      ended_d = 1'b1;
    end
  end

  // Per-bit flags: clear beats set, otherwise hold.
  assign flags_d = (flags_q | flag_set) & ~flag_clr;

  // Counter, ended and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= CNT_MAX;
      ended_q <= 1'b0;
      flags_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ended_q <= ended_d;
      flags_q <= flags_d;
    end
  end

  assign fwd_ended = ended_q;
  assign flags     = flags_q;

`ifdef L2_CTRL_REGS_ERR_EN
  logic [1:0] err_q;

  // Sticky misuse flags: bit0 alloc with no free entry, bit1 free with every entry already free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_q | {free_only & reqs_idle, alloc_only & reqs_full};
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_l2_ctrl_regs.sv
// Bench for l2_ctrl_regs with N_SETS=4, N_WAYS=2, N_REQS=4, N_FWD=2, N_FLAGS=4.
// Latency: checks sample #1 after each rising edge.
// Backpressure: n/a.
module tb_l2_ctrl_regs;

  typedef struct packed {
    logic       start, step, abort, alloc, free, push;
    logic [1:0] push_idx;
    logic       put;
    logic [1:0] put_idx;
    logic       atomic;
    logic [1:0] atomic_idx;
    logic       clr_ended;
    logic [3:0] fset, fclr;
  } in_t;

  typedef struct packed {
    logic [1:0] set;
    logic       way, busy, done;
    logic [2:0] cnt;
    logic       full, idle, stall, sfull, ended;
    logic [3:0] flags;
  } exp_t;

  typedef struct {
    string      name;
    in_t        i;
    logic [2:0] cnt;
    logic       stall, sfull, ended;
    logic [3:0] flags;
  } vec_t;

  logic       clk, rst;
  logic       flush_start, flush_step, flush_abort;
  logic [1:0] flush_set;
  logic       flush_way, flush_busy, flush_done;
  logic       req_alloc, req_free;
  logic [2:0] reqs_cnt;
  logic       reqs_full, reqs_idle;
  logic       fwd_push;
  logic [1:0] fwd_push_idx;
  logic       fwd_stall, fwd_slots_full;
  logic       put_valid, put_atomic;
  logic [1:0] put_idx, put_atomic_idx;
  logic       fwd_ended, clr_fwd_ended;
  logic [3:0] flag_set, flag_clr, flags;
`ifdef L2_CTRL_REGS_ERR_EN
  logic [1:0] err;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  vec_t tbl[$];
  exp_t act;

  l2_ctrl_regs #(
    .N_SETS(4), .N_WAYS(2), .N_REQS(4), .N_FWD(2), .N_FLAGS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .flush_start(flush_start), .flush_step(flush_step), .flush_abort(flush_abort),
    .flush_set(flush_set), .flush_way(flush_way), .flush_busy(flush_busy), .flush_done(flush_done),
    .req_alloc(req_alloc), .req_free(req_free),
    .reqs_cnt(reqs_cnt), .reqs_full(reqs_full), .reqs_idle(reqs_idle),
    .fwd_push(fwd_push), .fwd_push_idx(fwd_push_idx),
    .fwd_stall(fwd_stall), .fwd_slots_full(fwd_slots_full),
    .put_valid(put_valid), .put_idx(put_idx), .put_atomic(put_atomic),
    .put_atomic_idx(put_atomic_idx), .fwd_ended(fwd_ended), .clr_fwd_ended(clr_fwd_ended),
    .flag_set(flag_set), .flag_clr(flag_clr), .flags(flags)
`ifdef L2_CTRL_REGS_ERR_EN
    , .err(err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = {flush_set, flush_way, flush_busy, flush_done, reqs_cnt, reqs_full, reqs_idle,
                fwd_stall, fwd_slots_full, fwd_ended, flags};

  task automatic drive(input in_t i);
    flush_start    = i.start;
    flush_step     = i.step;
    flush_abort    = i.abort;
    req_alloc      = i.alloc;
    req_free       = i.free;
    fwd_push       = i.push;
    fwd_push_idx   = i.push_idx;
    put_valid      = i.put;
    put_idx        = i.put_idx;
    put_atomic     = i.atomic;
    put_atomic_idx = i.atomic_idx;
    clr_fwd_ended  = i.clr_ended;
    flag_set       = i.fset;
    flag_clr       = i.fclr;
  endtask

  task automatic compare(input exp_t e, input exp_t care, input string name);
    logic [16:0] a, x, m;
    a = act;
    x = e;
    m = care;
    checks++;
    if ((a & m) !== (x & m)) begin
      failures++;
      $display("FAIL %s: got %h required %h (care %h)", name, a, x, m);
    end
  endtask

  // Drive one cycle, queue the expectation, compare after the edge.
  task automatic cycle(input in_t i, input exp_t e, input exp_t care, input string name);
    exp_t x;
    @(negedge clk);
    drive(i);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    compare(x, care, name);
  endtask

  task automatic add(input string n, input in_t i, input logic [2:0] c, input logic st,
                     input logic sf, input logic en, input logic [3:0] fl);
    vec_t v;
    v.name = n; v.i = i; v.cnt = c; v.stall = st; v.sfull = sf; v.ended = en; v.flags = fl;
    tbl.push_back(v);
  endtask

  task automatic check_err(input logic [1:0] want, input string name);
`ifdef L2_CTRL_REGS_ERR_EN
    checks++;
    if (err !== want) begin
      failures++;
      $display("FAIL %s: err got %b required %b", name, err, want);
    end
`else
    if (want === 2'bxx) $display("unused %s", name);
`endif
  endtask

  initial begin
    in_t  nop, s;
    exp_t rst_e, e, all, nopos;

    nop   = '0;
    all   = '1;
    nopos = '1;
    nopos.set = 2'b00;
    nopos.way = 1'b0;
    rst_e = '0;
    rst_e.cnt  = 3'd4;
    rst_e.idle = 1'b1;

    add("alloc_3",         in_t'{alloc:1'b1, default:'0},                           3'd3, 0, 0, 0, 4'h0);
    add("alloc_2",         in_t'{alloc:1'b1, default:'0},                           3'd2, 0, 0, 0, 4'h0);
    add("alloc_free_at_2", in_t'{alloc:1'b1, free:1'b1, default:'0},                3'd2, 0, 0, 0, 4'h0);
    add("alloc_1",         in_t'{alloc:1'b1, default:'0},                           3'd1, 0, 0, 0, 4'h0);
    add("alloc_0_full",    in_t'{alloc:1'b1, default:'0},                           3'd0, 0, 0, 0, 4'h0);
    add("alloc_sat_0",     in_t'{alloc:1'b1, default:'0},                           3'd0, 0, 0, 0, 4'h0);
    add("free_1",          in_t'{free:1'b1, default:'0},                            3'd1, 0, 0, 0, 4'h0);
    add("free_2",          in_t'{free:1'b1, default:'0},                            3'd2, 0, 0, 0, 4'h0);
    add("free_3",          in_t'{free:1'b1, default:'0},                            3'd3, 0, 0, 0, 4'h0);
    add("free_4_idle",     in_t'{free:1'b1, default:'0},                            3'd4, 0, 0, 0, 4'h0);
    add("free_sat_4",      in_t'{free:1'b1, default:'0},                            3'd4, 0, 0, 0, 4'h0);
    add("push_3",          in_t'{push:1'b1, push_idx:2'd3, default:'0},             3'd4, 1, 0, 0, 4'h0);
    add("push_1_full",     in_t'{push:1'b1, push_idx:2'd1, default:'0},             3'd4, 1, 1, 0, 4'h0);
    add("push_2_dropped",  in_t'{push:1'b1, push_idx:2'd2, default:'0},             3'd4, 1, 1, 0, 4'h0);
    add("put_1",           in_t'{put:1'b1, put_idx:2'd1, default:'0},               3'd4, 1, 0, 1, 4'h0);
    add("clr_ended",       in_t'{clr_ended:1'b1, default:'0},                       3'd4, 1, 0, 0, 4'h0);
    add("put_2_nomatch",   in_t'{put:1'b1, put_idx:2'd2, default:'0},               3'd4, 1, 0, 0, 4'h0);
    add("put_atomic_3",    in_t'{put:1'b1, atomic:1'b1, atomic_idx:2'd3, default:'0}, 3'd4, 0, 0, 1, 4'h0);
    add("push_2",          in_t'{push:1'b1, push_idx:2'd2, default:'0},             3'd4, 1, 0, 1, 4'h0);
    add("put_2_clr_wins",  in_t'{put:1'b1, put_idx:2'd2, clr_ended:1'b1, default:'0}, 3'd4, 0, 0, 0, 4'h0);
    add("push_put_same_0", in_t'{push:1'b1, push_idx:2'd0, put:1'b1, put_idx:2'd0, default:'0}, 3'd4, 1, 0, 0, 4'h0);
    add("put_0",           in_t'{put:1'b1, put_idx:2'd0, default:'0},               3'd4, 0, 0, 1, 4'h0);
    add("clr_ended_2",     in_t'{clr_ended:1'b1, default:'0},                       3'd4, 0, 0, 0, 4'h0);
    add("flag_set_5",      in_t'{fset:4'b0101, default:'0},                         3'd4, 0, 0, 0, 4'b0101);
    add("flag_setclr_b2",  in_t'{fset:4'b0100, fclr:4'b0100, default:'0},           3'd4, 0, 0, 0, 4'b0001);
    add("flag_set_a",      in_t'{fset:4'b1010, default:'0},                         3'd4, 0, 0, 0, 4'b1011);
    add("flag_hold",       nop,                                                     3'd4, 0, 0, 0, 4'b1011);
    add("flag_clr_3",      in_t'{fclr:4'b0011, default:'0},                         3'd4, 0, 0, 0, 4'b1000);

    // Reset state.
    rst = 1'b0;
    drive(nop);
    repeat (2) @(posedge clk);
    #1;
    compare(rst_e, all, "reset_state");
    check_err(2'b00, "reset_err");
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[k]) begin
      e       = '0;
      e.cnt   = tbl[k].cnt;
      e.full  = (tbl[k].cnt == 3'd0);
      e.idle  = (tbl[k].cnt == 3'd4);
      e.stall = tbl[k].stall;
      e.sfull = tbl[k].sfull;
      e.ended = tbl[k].ended;
      e.flags = tbl[k].flags;
      cycle(tbl[k].i, e, all, tbl[k].name);
    end
    check_err(2'b11, "err_sticky_both");

    // Full walk: start, eight steps, one-cycle done, back to idle.
    e = rst_e;
    e.flags = 4'b1000;
    e.busy  = 1'b1;
    cycle(in_t'{start:1'b1, default:'0}, e, all, "walk_start");
    for (int k = 1; k <= 7; k++) begin
      s = in_t'{step:1'b1, default:'0};
      if (k == 3) s.start = 1'b1;
      e.set = 2'(k >> 1);
      e.way = 1'(k & 1);
      cycle(s, e, all, $sformatf("walk_step_%0d", k));
    end
    e.done = 1'b1;
    cycle(in_t'{step:1'b1, default:'0}, e, nopos, "walk_done_pulse");
    e.done = 1'b0;
    e.busy = 1'b0;
    e.set  = 2'd0;
    e.way  = 1'b0;
    cycle(nop, e, all, "walk_back_idle");
    cycle(nop, e, all, "walk_done_once");

    // Abort together with step at (1,1).
    e.busy = 1'b1;
    cycle(in_t'{start:1'b1, default:'0}, e, all, "abort_start");
    for (int k = 1; k <= 3; k++) begin
      e.set = 2'(k >> 1);
      e.way = 1'(k & 1);
      cycle(in_t'{step:1'b1, default:'0}, e, all, $sformatf("abort_step_%0d", k));
    end
    e.busy = 1'b0;
    e.set  = 2'd0;
    e.way  = 1'b0;
    cycle(in_t'{abort:1'b1, step:1'b1, default:'0}, e, all, "abort_idle");
    cycle(nop, e, all, "abort_no_done");

    // Reset while walking at (2,0) with other state disturbed.
    e.busy = 1'b1;
    cycle(in_t'{start:1'b1, default:'0}, e, all, "rstwalk_start");
    for (int k = 1; k <= 4; k++) begin
      s = in_t'{step:1'b1, default:'0};
      e.set = 2'(k >> 1);
      e.way = 1'(k & 1);
      if (k == 4) begin
        s.alloc = 1'b1; s.push = 1'b1; s.push_idx = 2'd1; s.fset = 4'b0010;
        e.cnt = 3'd3; e.idle = 1'b0; e.stall = 1'b1; e.flags = 4'b1010;
      end
      cycle(s, e, all, $sformatf("rstwalk_step_%0d", k));
    end
    @(negedge clk);
    drive(nop);
    rst = 1'b0;
    #1;
    compare(rst_e, all, "midwalk_reset");
    check_err(2'b00, "midwalk_reset_err");
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) cycle(nop, rst_e, all, $sformatf("post_reset_%0d", k));

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_ctrl_regs.md
L2_CTRL_REGS -- requirements
Module: l2_ctrl_regs

Interface
REQ-001 SHALL have parameter N_SETS, 256, L2 sets walked by flush (power of 2, >=2).
REQ-002 SHALL have parameter N_WAYS, 8, L2 ways per set (power of 2, >=2).
REQ-003 SHALL have parameter N_REQS, 4, outstanding request entries (>=2).
REQ-004 SHALL have parameter N_FWD, 2, forward-stall tracking slots (>=1).
REQ-005 SHALL have parameter N_FLAGS, 4, generic set/clear status flags (>=1).
REQ-006 SHALL have port clk  in  1  clock.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports flush_start, flush_step, flush_abort  in  1 each  begin walk / advance one way / cancel walk.
REQ-009 SHALL have ports flush_set  out  log2(N_SETS), flush_way  out  log2(N_WAYS), flush_busy  out  1, flush_done  out  1; these carry the current walk position, walk active, and a one-cycle walk-complete pulse.
REQ-010 SHALL have ports req_alloc, req_free  in  1 each  take/return one request entry.
REQ-011 SHALL have ports reqs_cnt  out  clog2(N_REQS+1)  free entries; reqs_full  out  1  (reqs_cnt==0); reqs_idle  out  1  (reqs_cnt==N_REQS).
REQ-012 SHALL have ports fwd_push  in  1 and fwd_push_idx  in  REQS_W  (the request index to stall on); fwd_stall  out  1  (any slot valid); fwd_slots_full  out  1.
REQ-013 SHALL have ports put_valid  in  1, put_idx  in  REQS_W, put_atomic  in  1, put_atomic_idx  in  REQS_W, fwd_ended  out  1 (sticky), clr_fwd_ended  in  1.
REQ-014 SHALL have ports flag_set, flag_clr  in  N_FLAGS; flags  out  N_FLAGS.

Function
REQ-015 SHALL run the flush FSM IDLE->WALK on flush_start; in WALK, each flush_step increments flush_way, and a way wrap to 0 increments flush_set.
REQ-016 SHALL, on flush_step at set N_SETS-1 / way N_WAYS-1, go to DONE; DONE SHALL assert flush_done for exactly one cycle, then return to IDLE with set/way zeroed.
REQ-017 SHALL make flush_abort beat flush_step: abort in WALK returns to IDLE, zeroes set/way, no flush_done; flush_start outside IDLE ignored.
REQ-018 SHALL assert flush_busy in WALK and DONE.
REQ-019 SHALL update reqs_cnt next cycle: alloc-only -1, free-only +1, both together unchanged; alloc at 0 and free at N_REQS SHALL leave the count unchanged (saturate).
REQ-020 SHALL store fwd_push_idx into the lowest-index invalid slot and mark it valid; push with all slots valid SHALL be dropped.
REQ-021 SHALL, on put_valid, invalidate every valid slot whose idx equals put_idx, or equals put_atomic_idx when put_atomic=1, and set fwd_ended next cycle.
REQ-022 SHALL let clr_fwd_ended beat a simultaneous match-set; a push in the same cycle as a matching put SHALL not match the newly pushed slot.
REQ-023 SHALL, per flag bit, give flag_clr priority over flag_set, and hold the bit otherwise.
REQ-024 SHALL keep all outputs registered, except reqs_full, reqs_idle, fwd_stall and fwd_slots_full, which decode from registers.

Reset
REQ-025 SHALL on rst low asynchronously force: FSM IDLE, flush_set/way 0, flush_busy/done 0, reqs_cnt N_REQS, all slots invalid, fwd_ended 0, flags 0.
REQ-026 SHALL on reset mid-walk discard the walk, with no flush_done pulse after release.

Configuration
REQ-027 SHALL, with L2_CTRL_REGS_ERR_EN defined, add output err  out  2: bit0 sticky on alloc at 0, bit1 sticky on free at N_REQS, cleared only by reset.
REQ-028 SHALL, without L2_CTRL_REGS_ERR_EN, omit the err port and its logic, with all other behaviour identical.

Structure
REQ-029 SHALL take default parameters, derived widths (SET_W, WAY_W, REQS_W) and the flush FSM state enum from the shared cache package.
REQ-030 SHALL implement the slots via one sub-module, l2_fwd_stall_slot, one instance per slot, holding valid, idx and match logic.

Verification
REQ-031 SHALL cover full walk with N_SETS=4, N_WAYS=2: start, then 8 steps -> positions (0,0)..(3,1), flush_done pulse in the cycle after the 8th step, then IDLE.
REQ-032 SHALL cover abort: abort+step together at (1,1) -> IDLE, (0,0), no flush_done.
REQ-033 SHALL cover reqs: 4 allocs -> reqs_cnt 0, reqs_full=1; 5th alloc -> still 0, err[0]=1 if enabled; simultaneous alloc+free at 2 -> stays 2.
REQ-034 SHALL cover fwd slots, N_FWD=2: push 3, push 1, third push dropped; put_idx=1 -> slot1 cleared, fwd_ended=1, fwd_stall=1; atomic put with put_atomic_idx=3 -> fwd_stall=0.
REQ-035 SHALL cover flags: set+clr on bit2 together -> 0; rst pulse mid-walk at (2,0) -> all REQ-025 values, no flush_done.
